// File: rtl/wheel_pulse_gen.sv
//============================================================================
// Module      : wheel_pulse_gen
// Description : Wheel-sensor square-wave generator and timed active-low button
//               press. Optional contact bounce enabled by WHEEL_BOUNCE_EN.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module wheel_pulse_gen #(
   parameter int CNT_W      = 24,
   parameter int PRESS_LEN  = 49_999,
   parameter int BOUNCE_CYC = 249
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             start,
   input  logic             stop,
   input  logic [CNT_W-1:0] half_period,
   input  logic [15:0]      pulse_num,
   input  logic             press_req,
   output logic             pulse_port,
   output logic             stat_port,
   output logic [15:0]      pulse_cnt,
   output logic             busy,
   output logic             done,
   output logic             press_busy
);

   localparam int c_MAXLEN = (PRESS_LEN > BOUNCE_CYC) ? PRESS_LEN : BOUNCE_CYC;
   localparam int c_PC_W   = $clog2(c_MAXLEN + 2);
   localparam logic [c_PC_W-1:0] c_PRESS_LEN = c_PC_W'(PRESS_LEN);
`ifdef WHEEL_BOUNCE_EN
   localparam logic [c_PC_W-1:0] c_BOUNCE = c_PC_W'(BOUNCE_CYC);
`endif

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} pulse_state_t;
   typedef enum logic [1:0] {P_IDLE = 2'd0, P_BOUNCE = 2'd1, P_HOLD = 2'd2} press_state_t;

   pulse_state_t      r_pstate;
   logic [CNT_W-1:0]  r_hp;
   logic [CNT_W-1:0]  r_phase;
   logic [15:0]       r_num;
   logic [15:0]       r_cnt;
   logic              r_pulse;
   logic              r_busy;
   logic              r_done;
   logic [15:0]       w_cnt_inc;

   press_state_t      r_kstate;
   logic [c_PC_W-1:0] r_pcnt;
   logic              r_stat;
   logic              r_pbusy;
`ifdef WHEEL_BOUNCE_EN
   logic [1:0]        r_bph;
`endif

   assign w_cnt_inc = r_cnt + 16'd1;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_pstate <= S_IDLE;
         r_hp     <= '0;
         r_phase  <= '0;
         r_num    <= '0;
         r_cnt    <= '0;
         r_pulse  <= 1'b1;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_pstate)
            S_IDLE: begin
               if (start && !stop) begin
                  r_hp     <= half_period;
                  r_num    <= pulse_num;
                  r_phase  <= half_period;
                  r_cnt    <= '0;
                  r_pulse  <= 1'b0;
                  r_busy   <= 1'b1;
                  r_pstate <= S_RUN;
               end
            end
            S_RUN: begin
               if (stop) begin
                  r_pulse  <= 1'b1;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
                  r_pstate <= S_IDLE;
               end else if (r_phase == '0) begin
                  r_phase <= r_hp;
                  r_pulse <= ~r_pulse;
                  // Rising edge: count it and end the train on the last pulse.
                  if (!r_pulse) begin
                     r_cnt <= w_cnt_inc;
                     if ((r_num != 16'd0) && (w_cnt_inc == r_num)) begin
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_pstate <= S_IDLE;
                     end
                  end
               end else begin
                  r_phase <= r_phase - CNT_W'(1);
               end
            end
            default: r_pstate <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_kstate <= P_IDLE;
         r_pcnt   <= '0;
         r_stat   <= 1'b1;
         r_pbusy  <= 1'b0;
`ifdef WHEEL_BOUNCE_EN
         r_bph    <= 2'd0;
`endif
      end else begin
         case (r_kstate)
            P_IDLE: begin
               if (press_req) begin
                  r_stat  <= 1'b0;
                  r_pbusy <= 1'b1;
`ifdef WHEEL_BOUNCE_EN
                  r_pcnt   <= c_BOUNCE;
                  r_bph    <= 2'd0;
                  r_kstate <= P_BOUNCE;
`else
                  r_pcnt   <= c_PRESS_LEN;
                  r_kstate <= P_HOLD;
`endif
               end
            end
`ifdef WHEEL_BOUNCE_EN
            P_BOUNCE: begin
               // Four alternating levels 0,1,0,1 before the settled low.
               if (r_pcnt == '0) begin
                  if (r_bph == 2'd3) begin
                     r_stat   <= 1'b0;
                     r_pcnt   <= c_PRESS_LEN;
                     r_kstate <= P_HOLD;
                  end else begin
                     r_bph  <= r_bph + 2'd1;
                     r_stat <= ~r_stat;
                     r_pcnt <= c_BOUNCE;
                  end
               end else begin
                  r_pcnt <= r_pcnt - c_PC_W'(1);
               end
            end
`endif
            P_HOLD: begin
               if (r_pcnt == '0) begin
                  r_stat   <= 1'b1;
                  r_pbusy  <= 1'b0;
                  r_kstate <= P_IDLE;
               end else begin
                  r_pcnt <= r_pcnt - c_PC_W'(1);
               end
            end
            default: r_kstate <= P_IDLE;
         endcase
      end
   end

   assign pulse_port = r_pulse;
   assign pulse_cnt  = r_cnt;
   assign busy       = r_busy;
   assign done       = r_done;
   assign stat_port  = r_stat;
   assign press_busy = r_pbusy;

endmodule

`default_nettype wire
